// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter sharing one z = x | ~y evaluator across N_REQ requesters.
// Optional statistics counters are enabled with GATE_EVAL_ARBITER_STATS_EN.
module gate_eval_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         x,
    input  logic [N_REQ-1:0]         y,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_z,
    input  logic                     rsp_ready
`ifdef GATE_EVAL_ARBITER_STATS_EN
    ,
    output logic [15:0]              eval_cnt,
    output logic [15:0]              one_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_id;
    logic          r_z;

    logic          w_allow;
    logic          w_found;
    logic          w_grant;
    logic [IW-1:0] w_idx;
    logic [IW:0]   w_sum;
    logic          w_z;
    logic [IW-1:0] w_ptr_nxt;

    assign w_allow = (r_state == EMPTY) || rsp_ready;

    // Scan requesters starting at the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N_REQ)) begin
                w_sum = w_sum - (IW+1)'(N_REQ);
            end
            if (!w_found && req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[IW-1:0];
            end
        end
    end

    assign w_grant   = w_allow && w_found && !areset;
    assign gnt       = w_grant ? (N_REQ'(1) << w_idx) : '0;
    assign w_z       = x[w_idx] | ~y[w_idx];
    assign w_ptr_nxt = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_z     <= 1'b0;
        end else if (w_grant) begin
            r_state <= FULL;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_idx;
            r_z     <= w_z;
        end else if (r_state == FULL && rsp_ready) begin
            r_state <= EMPTY;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_id    = r_id;
    assign rsp_z     = r_z;

`ifdef GATE_EVAL_ARBITER_STATS_EN
    logic [15:0] r_eval_cnt;
    logic [15:0] r_one_cnt;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_eval_cnt <= '0;
            r_one_cnt  <= '0;
        end else if (w_grant) begin
            r_eval_cnt <= r_eval_cnt + 16'd1;
            if (w_z) begin
                r_one_cnt <= r_one_cnt + 16'd1;
            end
        end
    end

    assign eval_cnt = r_eval_cnt;
    assign one_cnt  = r_one_cnt;
`endif

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Self-checking bench for gate_eval_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_gate_eval_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] gnt;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic         rsp_z;
`ifdef GATE_EVAL_ARBITER_STATS_EN
    logic [15:0]  eval_cnt;
    logic [15:0]  one_cnt;
`endif

    gate_eval_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .areset    (areset),
        .req       (req),
        .x         (x),
        .y         (y),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ready (rsp_ready)
`ifdef GATE_EVAL_ARBITER_STATS_EN
        ,
        .eval_cnt  (eval_cnt),
        .one_cnt   (one_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: the pending response and the arbitration pointer.
    bit           m_valid = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    bit           m_z = 0;
    int           m_eval = 0;
    int           m_one = 0;
    logic [N-1:0] last_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_z     = 0;
        m_eval  = 0;
        m_one   = 0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] xi,
                         input logic [N-1:0] yi, input logic rdy);
        int k;
        logic [N-1:0] eg;
        @(negedge clk);
        req = r;
        x = xi;
        y = yi;
        rsp_ready = rdy;
        #1;
        k  = (!m_valid || rdy) ? pick(r, m_ptr) : -1;
        eg = (k >= 0) ? (N'(1) << k) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_z", 32'(rsp_z), 32'(m_z));
`ifdef GATE_EVAL_ARBITER_STATS_EN
        chk("eval_cnt", 32'(eval_cnt), 32'(m_eval));
        chk("one_cnt", 32'(one_cnt), 32'(m_one));
`endif
        last_gnt = gnt;
        @(posedge clk);
        if (k >= 0) begin
            m_valid = 1;
            m_id    = k;
            m_z     = xi[k] | ~yi[k];
            m_ptr   = (k + 1) % N;
            m_eval  = (m_eval + 1) % 65536;
            if (m_z) m_one = (m_one + 1) % 65536;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        req = '1;
        rsp_ready = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_valid", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        areset = 1'b0;
        req = '0;
        rsp_ready = 1'b0;
        model_reset();
    endtask

    logic [N-1:0] cr = '0;
    logic [N-1:0] cx = '0;
    logic [N-1:0] cy = '0;

    initial begin
        req = '1;
        #1;
        chk("por_gnt", 32'(gnt), 32'(0));
        chk("por_valid", 32'(rsp_valid), 32'(0));
        chk("por_id", 32'(rsp_id), 32'(0));
        chk("por_z", 32'(rsp_z), 32'(0));
        @(negedge clk);
        areset = 1'b0;
        req = '0;

        // Single request, x=0 y=1 gives z=0.
        cycle(4'b0001, 4'b0000, 4'b0001, 1'b1);
        chk("r31_gnt", 32'(last_gnt), 32'(4'b0001));
        #1;
        chk("r31_valid", 32'(rsp_valid), 32'(1));
        chk("r31_id", 32'(rsp_id), 32'(0));
        chk("r31_z", 32'(rsp_z), 32'(0));

        // Back-to-back sweep of all operand pairs.
        do_reset();
        cycle(4'b1111, 4'b1100, 4'b1010, 1'b1);
        chk("r32_g0", 32'(last_gnt), 32'(4'b0001));
        #1 chk("r32_z0", 32'(rsp_z), 32'(1));
        cycle(4'b1110, 4'b1100, 4'b1010, 1'b1);
        chk("r32_g1", 32'(last_gnt), 32'(4'b0010));
        #1 chk("r32_z1", 32'(rsp_z), 32'(0));
        cycle(4'b1100, 4'b1100, 4'b1010, 1'b1);
        chk("r32_g2", 32'(last_gnt), 32'(4'b0100));
        #1 chk("r32_z2", 32'(rsp_z), 32'(1));
        cycle(4'b1000, 4'b1100, 4'b1010, 1'b1);
        chk("r32_g3", 32'(last_gnt), 32'(4'b1000));
        #1 chk("r32_z3", 32'(rsp_z), 32'(1));
        cycle(4'b0000, 4'b1100, 4'b1010, 1'b1);
        chk("r32_gnone", 32'(last_gnt), 32'(0));

        // Wrap-around after a grant to the last requester.
        cycle(4'b1001, 4'b0000, 4'b0000, 1'b1);
        chk("r34_wrap", 32'(last_gnt), 32'(4'b0001));

        // Backpressure holds the response and blocks grants.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0110, 4'b0000, 4'b0000, 1'b0);
            chk("r33_stall", 32'(last_gnt), 32'(0));
            chk("r33_hold", 32'(rsp_id), 32'(0));
        end
        cycle(4'b0110, 4'b0000, 4'b0000, 1'b1);
        chk("r33_resume", 32'(last_gnt), 32'(4'b0010));

        // Mid-cycle reset pulse while FULL.
        @(negedge clk);
        req = '0;
        rsp_ready = 1'b0;
        #2 areset = 1'b1;
        #1 chk("r35_valid", 32'(rsp_valid), 32'(0));
        chk("r35_gnt", 32'(gnt), 32'(0));
        #1 areset = 1'b0;
        model_reset();
        cycle(4'b1000, 4'b0000, 4'b0000, 1'b1);
        chk("r35_g3", 32'(last_gnt), 32'(4'b1000));
        cycle(4'b1111, 4'b0000, 4'b0000, 1'b1);
        chk("r35_ptr0", 32'(last_gnt), 32'(4'b0001));

        // Random traffic: requests held until granted, occasionally dropped.
        cr = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (cr[i] && !last_gnt[i]) begin
                    if ($urandom_range(7) == 0) cr[i] = 1'b0;
                end else begin
                    cr[i] = 1'($urandom_range(1));
                    cx[i] = 1'($urandom_range(1));
                    cy[i] = 1'($urandom_range(1));
                end
            end
            cycle(cr, cx, cy, 1'($urandom_range(3) != 0));
        end

`ifdef GATE_EVAL_ARBITER_STATS_EN
        do_reset();
        for (int c = 0; c < 70000; c++) begin
            cycle(4'b0001, 4'b0001, 4'b0000, 1'b1);
        end
        #1;
        chk("r36_eval", 32'(eval_cnt), 32'(4464));
        chk("r36_one", 32'(one_cnt), 32'(4464));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
